// File: rtl/fetch_pc_unit.sv
// PC register and instruction-fetch front end: req/ack fetch from imem, valid/ready hand-off to decode.
// Optional macro FETCH_PERF_CNT_EN enables the accepted-instruction counter on o_fetch_count.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_exc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  input  logic        i_instr_ready,
  output logic [31:0] o_fetch_count
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_OUT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic        kill;
  logic        req;
  logic        redirect;
  logic [31:0] redirect_pc;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Exception wins over a branch arriving in the same cycle.
  assign redirect    = i_exc | i_branch_taken;
  assign redirect_pc = i_exc ? EXC_VECTOR : word_align(i_branch_target);

  assign o_imem_req  = req;
  assign o_imem_addr = pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_BOOT;
      pc            <= RESET_VECTOR;
      pend_pc       <= 32'd0;
      kill          <= 1'b0;
      req           <= 1'b0;
      o_instr_valid <= 1'b0;
      o_instr       <= 32'd0;
      o_instr_pc    <= 32'd0;
    end else begin
      case (state)
        S_BOOT: begin
          if (redirect) pc <= redirect_pc;
          state <= S_FETCH;
          req   <= 1'b1;
        end
        S_FETCH: begin
          if (i_imem_ack) begin
            if (kill || redirect) begin
              // Stale response: drop it and refetch from the redirect address.
              pc   <= redirect ? redirect_pc : pend_pc;
              kill <= 1'b0;
            end else begin
              o_instr       <= i_imem_rdata;
              o_instr_pc    <= pc;
              o_instr_valid <= 1'b1;
              pc            <= pc + 32'd4;
              req           <= 1'b0;
              state         <= S_OUT;
            end
          end else if (redirect) begin
            // Request must stay stable until ack; remember where to go afterwards.
            kill    <= 1'b1;
            pend_pc <= redirect_pc;
          end
        end
        S_OUT: begin
          if (redirect) begin
            o_instr_valid <= 1'b0;
            pc            <= redirect_pc;
            req           <= 1'b1;
            state         <= S_FETCH;
          end else if (i_instr_ready) begin
            o_instr_valid <= 1'b0;
            req           <= 1'b1;
            state         <= S_FETCH;
          end
        end
        default: begin
          state         <= S_BOOT;
          req           <= 1'b0;
          o_instr_valid <= 1'b0;
          kill          <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_count <= 32'd0;
    end else if (o_instr_valid && i_instr_ready && !redirect) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  assign o_fetch_count = fetch_count;
`else
  assign o_fetch_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: imem responder, decode sink and expected-instruction scoreboard.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        exc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic [31:0] fetch_count;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   accepted = 0;

  fetch_pc_unit dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .i_exc           (exc),
    .o_imem_req      (imem_req),
    .o_imem_addr     (imem_addr),
    .i_imem_ack      (imem_ack),
    .i_imem_rdata    (imem_rdata),
    .o_instr_valid   (instr_valid),
    .o_instr         (instr),
    .o_instr_pc      (instr_pc),
    .i_instr_ready   (instr_ready),
    .o_fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 20 && imem_req !== 1'b1; i++) tick();
    tests++;
    if (imem_req !== 1'b1) begin
      fails++;
      $display("FAIL %s: req timeout, got %b expected 1", name, imem_req);
    end
  endtask

  task automatic check_count(input string name);
    tests++;
`ifdef FETCH_PERF_CNT_EN
    if (fetch_count !== 32'(accepted)) begin
      fails++;
      $display("FAIL %s: fetch_count got %0d expected %0d", name, fetch_count, accepted);
    end
`else
    if (fetch_count !== 32'd0) begin
      fails++;
      $display("FAIL %s: fetch_count got %0d expected 0", name, fetch_count);
    end
`endif
  endtask

  // One complete fetch: ack after lat cycles, decode stalls rdy_wait cycles, then accepts.
  task automatic do_fetch(input int lat, input int rdy_wait, input logic [31:0] exp_addr);
    exp_t        e;
    logic [31:0] held_instr, held_pc;
    wait_req("fetch_req");
    tests++;
    if (imem_addr !== exp_addr) begin
      fails++;
      $display("FAIL fetch_addr: got %h expected %h", imem_addr, exp_addr);
    end
    for (int i = 0; i < lat; i++) begin
      tick();
      tests++;
      if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
        fails++;
        $display("FAIL addr_hold: req %b addr %h expected 1 %h", imem_req, imem_addr, exp_addr);
      end
    end
    imem_ack   = 1'b1;
    imem_rdata = mem_word(imem_addr);
    exp_q.push_back('{addr: exp_addr, data: mem_word(exp_addr)});
    tick();
    imem_ack = 1'b0;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard: got empty queue expected entry");
    end else begin
      e = exp_q.pop_front();
      if (instr_valid !== 1'b1 || instr !== e.data || instr_pc !== e.addr) begin
        fails++;
        $display("FAIL deliver: valid %b instr %h pc %h expected 1 %h %h",
                 instr_valid, instr, instr_pc, e.data, e.addr);
      end
    end
    held_instr = instr;
    held_pc    = instr_pc;
    for (int i = 0; i < rdy_wait; i++) begin
      tick();
      tests++;
      if (instr_valid !== 1'b1 || instr !== held_instr || instr_pc !== held_pc || imem_req !== 1'b0) begin
        fails++;
        $display("FAIL out_hold: valid %b instr %h pc %h req %b expected 1 %h %h 0",
                 instr_valid, instr, instr_pc, imem_req, held_instr, held_pc);
      end
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    accepted++;
    tests++;
    if (instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL valid_drop: got %b expected 0", instr_valid);
    end
    check_count("count_accept");
  endtask

  task automatic test_reset();
    rst_n = 1'b0; branch_taken = 1'b0; branch_target = '0; exc = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    #2;
    tests++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'd0 ||
        instr_pc !== 32'd0 || imem_addr !== 32'd0) begin
      fails++;
      $display("FAIL reset_outputs: req %b valid %b instr %h pc %h addr %h expected all 0",
               imem_req, instr_valid, instr, instr_pc, imem_addr);
    end
    check_count("reset_count");
    tick(); tick();
    rst_n = 1'b1;
    tests++;
    if (imem_req !== 1'b0) begin
      fails++;
      $display("FAIL boot_no_req: got %b expected 0", imem_req);
    end
  endtask

  task automatic test_sequential();
    do_fetch(0, 0, 32'h0);
    do_fetch(0, 0, 32'h4);
    do_fetch(0, 0, 32'h8);
  endtask

  task automatic test_stall();
    do_fetch(3, 4, 32'hC);
  endtask

  task automatic test_branch_pending();
    wait_req("bp_req");
    tests++;
    if (imem_addr !== 32'h10) begin
      fails++;
      $display("FAIL bp_addr: got %h expected 00000010", imem_addr);
    end
    branch_taken = 1'b1; branch_target = 32'h0000_0103;
    tick();
    branch_taken = 1'b0;
    tests++;
    if (imem_addr !== 32'h10 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_hold: addr %h req %b valid %b expected 00000010 1 0", imem_addr, imem_req, instr_valid);
    end
    tick();
    imem_ack = 1'b1; imem_rdata = mem_word(32'h10);
    tick();
    imem_ack = 1'b0;
    tests++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      fails++;
      $display("FAIL bp_discard: valid %b req %b addr %h expected 0 1 00000100", instr_valid, imem_req, imem_addr);
    end
    do_fetch(0, 0, 32'h100);
  endtask

  task automatic test_exc_priority();
    wait_req("exc_req");
    imem_ack = 1'b1; imem_rdata = mem_word(imem_addr);
    exc = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
    tick();
    imem_ack = 1'b0; exc = 1'b0; branch_taken = 1'b0;
    tests++;
    if (instr_valid !== 1'b0 || imem_addr !== 32'h80) begin
      fails++;
      $display("FAIL exc_redirect: valid %b addr %h expected 0 00000080", instr_valid, imem_addr);
    end
    do_fetch(1, 1, 32'h80);
  endtask

  task automatic test_out_redirect();
    wait_req("or_req");
    imem_ack = 1'b1; imem_rdata = mem_word(imem_addr);
    tick();
    imem_ack = 1'b0;
    tests++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h84) begin
      fails++;
      $display("FAIL or_valid: valid %b pc %h expected 1 00000084", instr_valid, instr_pc);
    end
    instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
    tick();
    instr_ready = 1'b0; branch_taken = 1'b0;
    tests++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      fails++;
      $display("FAIL or_redirect: valid %b req %b addr %h expected 0 1 00000040", instr_valid, imem_req, imem_addr);
    end
    check_count("or_count");
  endtask

  task automatic test_wrap();
    wait_req("wrap_req");
    imem_ack = 1'b1; imem_rdata = mem_word(imem_addr);
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    tick();
    imem_ack = 1'b0; branch_taken = 1'b0;
    do_fetch(0, 0, 32'hFFFF_FFFC);
    do_fetch(0, 2, 32'h0000_0000);
  endtask

  task automatic test_reset_mid();
    wait_req("rm_req");
    tick();
    rst_n = 1'b0;
    #1;
    tests++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'd0 ||
        instr_pc !== 32'd0 || imem_addr !== 32'd0 || fetch_count !== 32'd0) begin
      fails++;
      $display("FAIL mid_reset: req %b valid %b instr %h pc %h addr %h cnt %0d expected all 0",
               imem_req, instr_valid, instr, instr_pc, imem_addr, fetch_count);
    end
    accepted = 0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    do_fetch(0, 0, 32'h0);
    do_fetch(2, 1, 32'h4);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_pending();
    test_exc_priority();
    test_out_redirect();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Program-counter and instruction-fetch front end of the simple MIPS32 core.
- Holds the PC, issues word fetches to instruction memory over a req/ack handshake, and presents each fetched instruction with its PC to decode over a valid/ready handshake.
- Produces the sequential PC+4 internally.
- Applies branch/jump and exception redirects, including redirects that arrive while a fetch is outstanding.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- EXC_VECTOR, 32'h0000_0080, PC loaded on exception redirect.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_branch_taken  input  1  branch/jump redirect request, single-cycle pulse.
- i_branch_target  input  32  redirect address; bits [1:0] ignored and forced to 00.
- i_exc  input  1  exception redirect to EXC_VECTOR, single-cycle pulse.
- o_imem_req  output  1  fetch request.
- o_imem_addr  output  32  fetch word address.
- i_imem_ack  input  1  fetch complete; i_imem_rdata valid this cycle.
- i_imem_rdata  input  32  fetched instruction.
- o_instr_valid  output  1  o_instr/o_instr_pc valid for decode.
- o_instr  output  32  instruction.
- o_instr_pc  output  32  PC of o_instr.
- i_instr_ready  input  1  decode accepts the instruction.
- o_fetch_count  output  32  accepted-instruction counter (see Optional Feature).

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - pc=RESET_VECTOR; state=S_BOOT; kill=0; pend_pc=0.
  - Outputs 0: o_imem_req, o_instr_valid, o_instr, o_instr_pc, o_fetch_count.
  - o_imem_addr follows pc.
- States and transitions:
  - S_BOOT: one cycle after reset release, then S_FETCH. Redirects in S_BOOT load pc (exc > branch) and proceed to S_FETCH.
  - S_FETCH: o_imem_req=1, o_imem_addr=pc. Address is held stable until i_imem_ack.
  - S_FETCH, ack with no kill and no redirect this cycle: o_instr<=i_imem_rdata, o_instr_pc<=pc, o_instr_valid<=1, pc<=pc+4; go to S_OUT.
  - S_FETCH, redirect without ack: kill<=1, pend_pc<=target. A later redirect overwrites pend_pc (latest wins). Request and address stay unchanged.
  - S_FETCH, ack with kill=1 or a redirect this cycle: data discarded; pc<=this-cycle target if present, else pend_pc; kill<=0. Stay in S_FETCH; the new request is issued next cycle with the new address.
  - S_OUT: o_imem_req=0, o_instr_valid=1; outputs stable while i_instr_ready=0. On i_instr_ready=1, valid drops next cycle and the state returns to S_FETCH.
  - S_OUT, redirect: valid<=0, pc<=target, go to S_FETCH. This applies even if i_instr_ready=1 the same cycle; the instruction counts as not delivered.
- Priority: i_exc over i_branch_taken when both arrive in the same cycle.
- Latency: request issued in cycle N, ack in cycle N+k, o_instr_valid high in N+k+1. Minimum one instruction per 2 cycles with zero-wait memory. Back-to-back throughput is not required.
- PC arithmetic: pc+4 modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Ack outside S_FETCH is ignored.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: o_fetch_count increments by 1 on each cycle where o_instr_valid and i_instr_ready are both high and no redirect is present. It wraps at 2^32 and resets to 0.
- Undefined: counter logic is absent and o_fetch_count is tied to 0. The port list is unchanged.

Test Plan:
- Reset, then zero-wait ack with i_instr_ready=1 → fetch addresses 0x0, 0x4, 0x8. o_instr_pc matches each address; o_instr equals rdata.
- Memory acks 3 cycles after req; decode ready low for 4 cycles → o_imem_addr stable through the wait. o_instr/o_instr_pc held stable while ready is low. No new req until acceptance.
- Branch to 0x0000_0103 while a req to 0x10 is pending; ack 2 cycles later → 0x10 data never goes valid. Next req address is 0x0000_0100.
- i_exc and i_branch_taken (target 0x200) coincide with ack → data discarded; next req at 0x80.
- Sequential fetch reaching 0xFFFF_FFFC → the next req after that instruction is accepted is to 0x0000_0000.
- i_rst_n pulsed low mid-fetch → all outputs 0 immediately; after release, first req at RESET_VECTOR. With FETCH_PERF_CNT_EN defined, o_fetch_count equals the number of accepted instructions (e.g. 5 after five acceptances) and is 0 after reset.
